// File: rtl/seq_multiplier.sv
// Iterative 32x32 -> 64 multiplier (MULT/MULTU) with hi/lo result registers.
// One radix-2 shift-add step per cycle; pve drops for exactly 32 cycles per operation.
module seq_multiplier (
   input  logic        clk,
   input  logic        reset,
   input  logic        multstartE,
   input  logic        signedE,
   input  logic [31:0] srcaE,
   input  logic [31:0] srcbE,
   input  logic        mthiE,
   input  logic        mtloE,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        pve,
   output logic        busy
);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t      state_q, state_d;
   logic [5:0]  cnt_q, cnt_d;
   logic [31:0] mcand_q, mcand_d;
   logic [63:0] mplier_q, mplier_d;
   logic [63:0] acc_q, acc_d;
   logic        neg_q, neg_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
   logic        pve_q, pve_d;
   logic        busy_q, busy_d;
   logic [32:0] sum_s;
   logic [63:0] prod_s;

   // 33-bit magnitude so that -2^31 maps to 0x80000000 without overflow
   function automatic logic [31:0] magnitude(input logic [31:0] v, input logic sgn);
      logic [32:0] ext;
      logic [32:0] mag;
      ext = {sgn & v[31], v};
      if (ext[32]) begin
         mag = 33'd0 - ext;
      end else begin
         mag = ext;
      end
      return mag[31:0];
   endfunction

   function automatic logic [63:0] negate64(input logic [63:0] v);
      return 64'd0 - v;
   endfunction

   // Next-state, datapath step and output register updates
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      neg_d    = neg_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      pve_d    = pve_q;
      busy_d   = busy_q;
      sum_s    = 33'd0;
      prod_s   = 64'd0;
      case (state_q)
         IDLE: begin
            if (multstartE) begin
               mcand_d  = magnitude(srcaE, signedE);
               mplier_d = {32'd0, magnitude(srcbE, signedE)};
               neg_d    = signedE & (srcaE[31] ^ srcbE[31]);
               acc_d    = 64'd0;
               cnt_d    = 6'd0;
               pve_d    = 1'b0;
               busy_d   = 1'b1;
               state_d  = RUN;
            end else begin
               if (mthiE) begin
                  hi_d = srcaE;
               end else begin
                  hi_d = hi_q;
               end
               if (mtloE) begin
                  lo_d = srcaE;
               end else begin
                  lo_d = lo_q;
               end
            end
         end
         RUN: begin
            // add into the upper half, then shift the whole accumulator right
            sum_s    = {1'b0, acc_q[63:32]} + (mplier_q[0] ? {1'b0, mcand_q} : 33'd0);
            prod_s   = {sum_s, acc_q[31:1]};
            acc_d    = prod_s;
            mplier_d = {1'b0, mplier_q[63:1]};
            cnt_d    = cnt_q + 6'd1;
            if (cnt_q == 6'd31) begin
               if (neg_q) begin
                  {hi_d, lo_d} = negate64(prod_s);
               end else begin
                  {hi_d, lo_d} = prod_s;
               end
               pve_d   = 1'b1;
               busy_d  = 1'b0;
               state_d = IDLE;
            end else begin
               state_d = RUN;
            end
         end
         default: begin
            state_d = IDLE;
            pve_d   = 1'b1;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         cnt_q    <= 6'd0;
         mcand_q  <= 32'd0;
         mplier_q <= 64'd0;
         acc_q    <= 64'd0;
         neg_q    <= 1'b0;
         hi_q     <= 32'd0;
         lo_q     <= 32'd0;
         pve_q    <= 1'b1;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         neg_q    <= neg_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         pve_q    <= pve_d;
         busy_q   <= busy_d;
      end
   end

   assign hi   = hi_q;
   assign lo   = lo_q;
   assign pve  = pve_q;
   assign busy = busy_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed self-checking bench for seq_multiplier: products, latency, moves,
// ignored inputs during RUN and reset behaviour.
module tb_seq_multiplier;

   logic        clk;
   logic        reset;
   logic        multstartE;
   logic        signedE;
   logic [31:0] srcaE;
   logic [31:0] srcbE;
   logic        mthiE;
   logic        mtloE;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        pve;
   logic        busy;

   int checks = 0;
   int errors = 0;

   seq_multiplier dut (
      .clk        (clk),
      .reset      (reset),
      .multstartE (multstartE),
      .signedE    (signedE),
      .srcaE      (srcaE),
      .srcbE      (srcbE),
      .mthiE      (mthiE),
      .mtloE      (mtloE),
      .hi         (hi),
      .lo         (lo),
      .pve        (pve),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Present operands for one accepting edge; returns at the first RUN negedge
   task automatic start_mult(input logic s, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      multstartE = 1'b1; signedE = s; srcaE = a; srcbE = b;
      @(negedge clk);
      multstartE = 1'b0; signedE = 1'b0; srcaE = 32'd0; srcbE = 32'd0;
   endtask

   // Count cycles with pve low, bounded
   task automatic wait_done(output int lowc);
      lowc = 0;
      while (pve === 1'b0 && lowc < 100) begin
         lowc++;
         @(negedge clk);
      end
   endtask

   task automatic test_reset;
      reset = 1'b1; multstartE = 1'b1; mthiE = 1'b1; mtloE = 1'b1;
      signedE = 1'b0; srcaE = 32'h55; srcbE = 32'h3;
      repeat (3) @(negedge clk);
      multstartE = 1'b0; mthiE = 1'b0; mtloE = 1'b0; srcaE = 32'd0; srcbE = 32'd0;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if (hi !== 32'd0 || lo !== 32'd0) begin
         errors++; $display("FAIL reset_hilo: got hi=%h lo=%h, expected 0/0", hi, lo);
      end
      checks++;
      if (pve !== 1'b1 || busy !== 1'b0) begin
         errors++; $display("FAIL reset_pve: got pve=%b busy=%b, expected 1/0", pve, busy);
      end
   endtask

   task automatic test_products;
      logic        s_tab [7];
      logic [31:0] a_tab [7];
      logic [31:0] b_tab [7];
      logic [63:0] p_tab [7];
      int lowc;
      s_tab[0] = 1'b0; a_tab[0] = 32'd7;          b_tab[0] = 32'd6;          p_tab[0] = 64'h00000000_0000002A;
      s_tab[1] = 1'b1; a_tab[1] = 32'hFFFFFFFD;   b_tab[1] = 32'd5;          p_tab[1] = 64'hFFFFFFFF_FFFFFFF1;
      s_tab[2] = 1'b0; a_tab[2] = 32'hFFFFFFFF;   b_tab[2] = 32'hFFFFFFFF;   p_tab[2] = 64'hFFFFFFFE_00000001;
      s_tab[3] = 1'b1; a_tab[3] = 32'h80000000;   b_tab[3] = 32'h80000000;   p_tab[3] = 64'h40000000_00000000;
      s_tab[4] = 1'b1; a_tab[4] = 32'h80000000;   b_tab[4] = 32'd1;          p_tab[4] = 64'hFFFFFFFF_80000000;
      s_tab[5] = 1'b0; a_tab[5] = 32'd0;          b_tab[5] = 32'd12345;      p_tab[5] = 64'd0;
      s_tab[6] = 1'b1; a_tab[6] = 32'hFFFFFFFF;   b_tab[6] = 32'hFFFFFFFF;   p_tab[6] = 64'd1;
      for (int i = 0; i < 7; i++) begin
         start_mult(s_tab[i], a_tab[i], b_tab[i]);
         checks++;
         if (busy !== 1'b1) begin
            errors++; $display("FAIL busy_run[%0d]: got %b, expected 1", i, busy);
         end
         wait_done(lowc);
         checks++;
         if (lowc != 32) begin
            errors++; $display("FAIL latency[%0d]: got %0d cycles, expected 32", i, lowc);
         end
         checks++;
         if ({hi, lo} !== p_tab[i]) begin
            errors++; $display("FAIL product[%0d]: got %h_%h, expected %h", i, hi, lo, p_tab[i]);
         end
      end
   endtask

   task automatic test_ignore_in_run;
      int lowc;
      @(negedge clk);
      mthiE = 1'b1; srcaE = 32'hAAAA5555;
      @(negedge clk);
      mthiE = 1'b0; srcaE = 32'd0;
      start_mult(1'b0, 32'd2, 32'd3);
      lowc = 0;
      while (pve === 1'b0 && lowc < 100) begin
         lowc++;
         if (lowc == 10) begin
            multstartE = 1'b1; signedE = 1'b0; srcaE = 32'h1234; srcbE = 32'd9; mthiE = 1'b1;
         end else begin
            multstartE = 1'b0; srcaE = 32'd0; srcbE = 32'd0; mthiE = 1'b0;
         end
         if (lowc == 20) begin
            checks++;
            if (hi !== 32'hAAAA5555) begin
               errors++; $display("FAIL hold_in_run: got hi=%h, expected aaaa5555", hi);
            end
         end
         @(negedge clk);
      end
      checks++;
      if (lowc != 32) begin
         errors++; $display("FAIL ignore_latency: got %0d cycles, expected 32", lowc);
      end
      checks++;
      if (hi !== 32'd0 || lo !== 32'd6) begin
         errors++; $display("FAIL ignore_result: got hi=%h lo=%h, expected 0/6", hi, lo);
      end
      @(negedge clk);
      checks++;
      if (pve !== 1'b1) begin
         errors++; $display("FAIL no_restart: got pve=%b, expected 1", pve);
      end
   endtask

   task automatic test_moves;
      int lowc;
      @(negedge clk);
      mthiE = 1'b1; mtloE = 1'b1; srcaE = 32'hDEADBEEF;
      @(negedge clk);
      mthiE = 1'b0; mtloE = 1'b0; srcaE = 32'd0;
      checks++;
      if (hi !== 32'hDEADBEEF || lo !== 32'hDEADBEEF) begin
         errors++; $display("FAIL move_both: got hi=%h lo=%h, expected deadbeef", hi, lo);
      end
      @(negedge clk);
      multstartE = 1'b1; mtloE = 1'b1; signedE = 1'b0; srcaE = 32'd7; srcbE = 32'd6;
      @(negedge clk);
      multstartE = 1'b0; mtloE = 1'b0; srcaE = 32'd0; srcbE = 32'd0;
      checks++;
      if (lo !== 32'hDEADBEEF || pve !== 1'b0) begin
         errors++; $display("FAIL mult_wins: got lo=%h pve=%b, expected deadbeef/0", lo, pve);
      end
      wait_done(lowc);
      checks++;
      if (lowc != 32 || hi !== 32'd0 || lo !== 32'd42) begin
         errors++; $display("FAIL mult_wins_result: got %0d cycles hi=%h lo=%h, expected 32 0 2a", lowc, hi, lo);
      end
   endtask

   task automatic test_reset_mid_run;
      int lowc;
      start_mult(1'b0, 32'd100, 32'd100);
      repeat (14) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checks++;
      if (hi !== 32'd0 || lo !== 32'd0 || pve !== 1'b1 || busy !== 1'b0) begin
         errors++; $display("FAIL reset_mid: got hi=%h lo=%h pve=%b busy=%b, expected 0 0 1 0", hi, lo, pve, busy);
      end
      @(negedge clk);
      checks++;
      if (pve !== 1'b1 || lo !== 32'd0) begin
         errors++; $display("FAIL reset_abandon: got pve=%b lo=%h, expected 1/0", pve, lo);
      end
      start_mult(1'b0, 32'd4, 32'd4);
      wait_done(lowc);
      checks++;
      if (lowc != 32 || hi !== 32'd0 || lo !== 32'd16) begin
         errors++; $display("FAIL after_reset: got %0d cycles hi=%h lo=%h, expected 32 0 10", lowc, hi, lo);
      end
   endtask

   initial begin
      reset = 1'b1; multstartE = 1'b0; signedE = 1'b0;
      srcaE = 32'd0; srcbE = 32'd0; mthiE = 1'b0; mtloE = 1'b0;
      test_reset();
      test_products();
      test_ignore_in_run();
      test_moves();
      test_reset_mid_run();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
